c499_key_sequencer: RTL and testbench
=====================================

C499_KEY_SEQUENCER -- requirements
Module: c499_key_sequencer

Interface
REQ-001 Parameter KEY_W, default 27, key length: p1..p4 then X_1..X_23.
REQ-002 Parameter CORE_LAT, default 2, core settle cycles between issue and capture; legal range 1..15.
REQ-003 Ports are clk  in  1  single clock; all state on rising edge.
REQ-004 Ports are rst_n  in  1  asynchronous active-low reset.
REQ-005 Ports are key_start  in  1  begin or restart a serial key load.
REQ-006 Ports are key_bit  in  1  serial key data, MSB (p1) first.
REQ-007 Ports are key_par  in  1  expected even-parity bit, sampled with the last key bit.
REQ-008 Ports are key_ok  out  1  key loaded and accepted.
REQ-009 Ports are key_err  out  1  last load rejected.
REQ-010 Ports are key_out  out  KEY_W  key to the locked core.
REQ-011 Ports are in_valid/in_ready  in/out  1  word handshake; in_data  in  32 (N1..N125); in_chk  in  8 (N129..N136).
REQ-012 Ports are core_din  out  41  {enable (N137), chk, data} to core; core_res  in  32  core outputs N724..N755.
REQ-013 Ports are out_valid/out_ready  out/in  1  result handshake; out_data  out  32  captured result.

Function
REQ-014 FSM states: IDLE, LOAD, ARMED, WAIT, HOLD; encoding free.
REQ-015 IDLE + key_start -> LOAD; shift register and 5-bit bit counter cleared.
REQ-016 LOAD: one key_bit shifted per cycle, counter 0..KEY_W-1; cycle with counter=KEY_W-1 -> ARMED (accepted) or IDLE (rejected), next cycle.
REQ-017 key_start in any state other than IDLE aborts current activity, clears counter and shift register, drops key_ok and any pending result, enters LOAD; key_start wins over every simultaneous handshake.
REQ-018 key_out = shift register when key_ok=1, else all zeros; never changes while key_ok=1.
REQ-019 in_ready = 1 only in ARMED; transfer when in_valid && in_ready.
REQ-020 Transfer: core_din <= {1'b1, in_chk, in_data}; state -> WAIT; settle counter loaded with CORE_LAT-1.
REQ-021 WAIT: counter decrements each cycle; at 0, out_data <= core_res, out_valid <= 1, state -> HOLD; exactly CORE_LAT+1 cycles from accept edge to out_valid high.
REQ-022 HOLD: out_data and out_valid stable until out_valid && out_ready; then out_valid <= 0, state -> ARMED; in_ready rises the following cycle (no same-cycle accept).
REQ-023 core_din enable bit = 0 outside WAIT/HOLD; data/chk fields hold last value.
REQ-024 key_err set on rejection, cleared on next key_start.

Reset
REQ-025 rst_n low asynchronously forces IDLE, key_ok=0, key_err=0, key_out=0, in_ready=0, out_valid=0, out_data=0, core_din=0, counters 0.
REQ-026 Reset assertion mid-LOAD or mid-WAIT discards partial key and pending word; no output pulses on deassertion.

Configuration
REQ-027 Macro C499_KEY_PARITY_EN defined: load accepted only if XOR of all KEY_W bits equals key_par; mismatch -> IDLE, key_err=1, key_ok=0.
REQ-028 Macro undefined: key_par ignored; every complete load accepted; key_err constant 0.

Verification
REQ-029 Load 27 bits 0x5A5A5A5 (LSB-aligned) with correct parity -> key_ok=1 on cycle 28 after key_start, key_out=27'h5A5A5A5.
REQ-030 With C499_KEY_PARITY_EN, same load with key_par inverted -> key_err=1, key_ok=0, key_out=0, in_ready=0.
REQ-031 Key loaded, CORE_LAT=2, in_data=32'hDEADBEEF, core_res model returns 32'h12345678 -> out_valid high 3 cycles after accept, out_data=32'h12345678.
REQ-032 out_ready held low 10 cycles in HOLD -> out_data stable, in_ready=0 throughout; out_ready high -> in_ready=1 next cycle.
REQ-033 key_start asserted during WAIT -> out_valid never rises, key_ok=0 next cycle, reload of 27 bits restores ARMED.
REQ-034 rst_n pulsed low at bit 13 of a load -> all outputs 0 immediately; subsequent full load succeeds.

Source files
------------

// File: rtl/c499_key_sequencer.sv
// c499_key_sequencer: loads a serial unlock key for a logic-locked c499 core,
// then sequences 32-bit words through the core with a fixed settle latency.
// Each word is held on the core input while the core settles, the core output
// is captured, and the result is handed off on a valid/ready output port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_start           begin or restart a serial key load (wins over all else)
//   key_bit, key_par    serial key, MSB first; parity bit sampled with last bit
//   key_ok, key_err     key accepted / last load rejected
//   key_out[KEY_W]      key to the locked core, zero unless key_ok
//   in_valid/in_ready   input word handshake; in_data[32], in_chk[8]
//   core_din[41]        {enable, chk, data} to the core
//   core_res[32]        core result
//   out_valid/out_ready result handshake; out_data[32]
//
// Build option: define C499_KEY_PARITY_EN to reject loads whose XOR over all
// key bits differs from key_par; otherwise key_par is ignored and key_err
// stays 0.
module c499_key_sequencer #(
    parameter int unsigned KEY_W    = 27,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_bit,
    input  logic              key_par,
    output logic              key_ok,
    output logic              key_err,
    output logic [KEY_W-1:0]  key_out,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [7:0]        in_chk,
    output logic [40:0]       core_din,
    input  logic [31:0]       core_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHK_W  = 8;
    localparam int unsigned FLD_W  = DATA_W + CHK_W;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LAT_W  = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [KEY_W-1:0] shift_q,   shift_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

    logic             key_ok_d, key_err_d, in_ready_d, out_valid_d, core_en_d;
    logic [KEY_W-1:0] key_out_d;
    logic [31:0]      out_data_d;
    logic [FLD_W-1:0] fields_d;

    logic [KEY_W-1:0] shifted;
    logic             last_bit;
    logic             parity_ok;

    assign shifted  = {shift_q[KEY_W-2:0], key_bit};
    assign last_bit = (bit_cnt_q == CNT_W'(KEY_W - 1));

`ifdef C499_KEY_PARITY_EN
    // Parity covers the full key including the bit shifted in this cycle.
    assign parity_ok = ((^shifted) == key_par);
`else
    logic unused_key_par;
    assign unused_key_par = key_par;
    assign parity_ok      = 1'b1;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            lat_cnt_q <= '0;
            key_ok    <= 1'b0;
            key_err   <= 1'b0;
            key_out   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            core_din  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            lat_cnt_q <= lat_cnt_d;
            key_ok    <= key_ok_d;
            key_err   <= key_err_d;
            key_out   <= key_out_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            core_din  <= {core_en_d, fields_d};
        end
    end

    // Next-state and next-output logic; key_start overrides every state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        lat_cnt_d   = lat_cnt_q;
        key_ok_d    = key_ok;
        key_err_d   = key_err;
        key_out_d   = key_out;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        fields_d    = core_din[FLD_W-1:0];

        if (key_start) begin
            state_d     = S_LOAD;
            bit_cnt_d   = '0;
            shift_d     = '0;
            lat_cnt_d   = '0;
            key_ok_d    = 1'b0;
            key_err_d   = 1'b0;
            key_out_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (parity_ok) begin
                            state_d   = S_ARMED;
                            key_ok_d  = 1'b1;
                            key_out_d = shifted;
                        end else begin
                            state_d   = S_IDLE;
                            key_err_d = 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (in_valid && in_ready) begin
                        fields_d  = {in_chk, in_data};
                        lat_cnt_d = LAT_W'(CORE_LAT - 1);
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        out_data_d  = core_res;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_ARMED;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Ready and core enable follow the state being entered.
        in_ready_d = (state_d == S_ARMED);
        core_en_d  = (state_d == S_WAIT) || (state_d == S_HOLD);
    end

endmodule

// File: tb/tb_c499_key_sequencer.sv
// Directed bench for c499_key_sequencer: key load, core round trips,
// backpressure, abort by key_start, asynchronous reset mid-load.
module tb_c499_key_sequencer;

    localparam int unsigned KEY_W    = 27;
    localparam int unsigned CORE_LAT = 2;
    localparam logic [31:0] CORE_K  = 32'hCC99E897;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_start, key_bit, key_par;
    logic              key_ok, key_err;
    logic [KEY_W-1:0]  key_out;
    logic              in_valid, in_ready;
    logic [31:0]       in_data;
    logic [7:0]        in_chk;
    logic [40:0]       core_din;
    logic [31:0]       core_res;
    logic              out_valid, out_ready;
    logic [31:0]       out_data;

    int checks   = 0;
    int failures = 0;
    logic ov_seen;

    always #5 clk = ~clk;

    // Core stand-in: DEADBEEF with chk 00 yields 12345678.
    assign core_res = core_din[40] ? (core_din[31:0] ^ CORE_K ^ {24'h0, core_din[39:32]}) : 32'h0;

    c499_key_sequencer #(.KEY_W(KEY_W), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start(key_start), .key_bit(key_bit), .key_par(key_par),
        .key_ok(key_ok), .key_err(key_err), .key_out(key_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
        .core_din(core_din), .core_res(core_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for checks and drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ov_seen = ov_seen | out_valid;
    endtask

    task automatic shift_bits(input logic [KEY_W-1:0] key, input logic par, input int nbits);
        key_par = par;
        for (int i = 0; i < nbits; i++) begin
            key_bit = key[KEY_W-1-i];
            if (i == KEY_W - 1) check("key_ok_low_before_last_bit", 64'(key_ok), 64'd0);
            tick();
        end
        key_bit = 1'b0;
    endtask

    task automatic start_load();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    initial begin
        logic [KEY_W-1:0] key_a;
        logic [KEY_W-1:0] key_b;
        logic [31:0]      held;
        key_a = 27'h5A5A5A5;
        key_b = 27'h2ABCDEF;
        ov_seen = 1'b0;

        rst_n = 1'b0; key_start = 1'b0; key_bit = 1'b0; key_par = 1'b0;
        in_valid = 1'b0; in_data = '0; in_chk = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_key_ok",    64'(key_ok),    64'd0);
        check("rst_key_err",   64'(key_err),   64'd0);
        check("rst_key_out",   64'(key_out),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_core_din",  64'(core_din),  64'd0);
        rst_n = 1'b1;
        tick();

        // Key 5A5A5A5 has 14 ones, so even parity bit is 0.
        start_load();
        shift_bits(key_a, 1'b0, KEY_W);
        check("load_key_ok",   64'(key_ok),   64'd1);
        check("load_key_out",  64'(key_out),  64'h5A5A5A5);
        check("load_key_err",  64'(key_err),  64'd0);
        check("load_in_ready", 64'(in_ready), 64'd1);

`ifdef C499_KEY_PARITY_EN
        start_load();
        shift_bits(key_a, 1'b1, KEY_W);
        check("badpar_key_err",  64'(key_err),  64'd1);
        check("badpar_key_ok",   64'(key_ok),   64'd0);
        check("badpar_key_out",  64'(key_out),  64'd0);
        check("badpar_in_ready", 64'(in_ready), 64'd0);
        start_load();
        check("badpar_err_cleared", 64'(key_err), 64'd0);
        shift_bits(key_a, 1'b0, KEY_W);
        check("reload_key_ok", 64'(key_ok), 64'd1);
`else
        start_load();
        shift_bits(key_a, 1'b1, KEY_W);
        check("nopar_key_ok",  64'(key_ok),  64'd1);
        check("nopar_key_err", 64'(key_err), 64'd0);
        check("nopar_key_out", 64'(key_out), 64'h5A5A5A5);
`endif

        // Word 1: accept, settle, capture on the CORE_LAT-th edge after accept.
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_chk = 8'h00;
        tick();
        in_valid = 1'b0;
        check("w1_core_din",  64'(core_din),  64'h1_00_DEADBEEF);
        check("w1_in_ready",  64'(in_ready),  64'd0);
        check("w1_ov_early",  64'(out_valid), 64'd0);
        tick();
        check("w1_ov_early2", 64'(out_valid), 64'd0);
        tick();
        check("w1_out_valid", 64'(out_valid), 64'd1);
        check("w1_out_data",  64'(out_data),  64'h12345678);

        // Backpressure: result and handshake hold while out_ready is low.
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_data",  64'(out_data),  64'(held));
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_in_ready",  64'(in_ready),  64'd1);
        check("rel_core_din",  64'(core_din),  64'h0_00_DEADBEEF);

        // Word 2 with nonzero chk and out_ready already high.
        in_valid = 1'b1; in_data = 32'h0F1E2D3C; in_chk = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("w2_core_din", 64'(core_din), 64'h1_3C_0F1E2D3C);
        tick();
        tick();
        check("w2_out_valid", 64'(out_valid), 64'd1);
        check("w2_out_data",  64'(out_data),  64'(32'h0F1E2D3C ^ CORE_K ^ 32'h0000003C));
        tick();
        out_ready = 1'b0;
        check("w2_done_out_valid", 64'(out_valid), 64'd0);
        check("w2_done_in_ready",  64'(in_ready),  64'd1);

        // Abort during WAIT with key_start, then reload a different key.
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_chk = 8'h11;
        tick();
        in_valid = 1'b0;
        check("abort_in_wait", 64'(core_din[40]), 64'd1);
        key_start = 1'b1;
        ov_seen = 1'b0;
        tick();
        key_start = 1'b0;
        check("abort_key_ok",    64'(key_ok),       64'd0);
        check("abort_key_out",   64'(key_out),      64'd0);
        check("abort_out_valid", 64'(out_valid),    64'd0);
        check("abort_core_en",   64'(core_din[40]), 64'd0);
        out_ready = 1'b1;
        shift_bits(key_b, ^key_b, KEY_W);
        out_ready = 1'b0;
        check("abort_ov_never",   64'(ov_seen),  64'd0);
        check("abort_reload_ok",  64'(key_ok),   64'd1);
        check("abort_reload_key", 64'(key_out),  64'(key_b));
        check("abort_armed",      64'(in_ready), 64'd1);

        // Reset mid-load after 13 bits clears everything without a clock edge.
        start_load();
        shift_bits(key_a, 1'b0, 13);
        rst_n = 1'b0;
        #1;
        check("arst_core_din",  64'(core_din),  64'd0);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_key_ok",    64'(key_ok),    64'd0);
        check("arst_key_out",   64'(key_out),   64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        tick(); tick();
        check("post_rst_key_ok",   64'(key_ok),   64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd0);
        check("post_rst_no_ov",    64'(ov_seen),  64'd0);
        start_load();
        shift_bits(key_a, 1'b0, KEY_W);
        check("post_rst_load_ok",  64'(key_ok),  64'd1);
        check("post_rst_load_key", 64'(key_out), 64'h5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
